// File: rtl/neopixel_pkg.sv
// Shared encodings and helpers for the NeoPixel pattern generator.
package neopixel_pkg;

    localparam int unsigned COLOR_W = 24;

    typedef enum logic [1:0] {
        MODE_INCREMENT = 2'd0,
        MODE_CHASE     = 2'd1,
        MODE_FADE      = 2'd2,
        MODE_HOLD      = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_READ_WAIT = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Halve each 8-bit channel of a 24-bit colour independently.
    function automatic logic [COLOR_W-1:0] fade_colour(input logic [COLOR_W-1:0] c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

endpackage

// File: rtl/neopixel_frame_timer.sv
// Free-running frame period counter: one-cycle trigger every C_RATE enabled clocks.
module neopixel_frame_timer #(
    parameter int unsigned C_RATE = 125000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic trigger
);

    localparam int unsigned CNT_W = $clog2(C_RATE + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Count runs 1..C_RATE and reloads to 1 after the terminal value.
    always_comb begin
        count_next = (count == CNT_W'(C_RATE)) ? CNT_W'(1) : count + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count   <= '0;
            trigger <= 1'b0;
        end else begin
            count   <= count_next;
            trigger <= (count_next == CNT_W'(C_RATE));
        end
    end

endmodule

// File: rtl/neopixel_pattern_gen.sv
// Frame-based pixel pattern generator driving a simple read/write control bus.
module neopixel_pattern_gen
    import neopixel_pkg::*;
#(
    parameter int unsigned          C_RATE   = 125000000,
    parameter int unsigned          C_PIXELS = 12,
    parameter logic [COLOR_W-1:0]   C_STEP   = 24'h040201
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    output logic        clock_ctrl,
    output logic        reset_ctrl,
    output logic        write_readf,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  missed_frames
);

    localparam logic [31:0] LAST_PIXEL = 32'(C_PIXELS - 1);

    state_t             state;
    mode_t              mode_q;
    mode_t              mode_in;
    logic [COLOR_W-1:0] base_colour;
    logic [31:0]        chase_pos;
    logic               trigger;
    logic               unused_read_hi;

    assign clock_ctrl     = clock;
    assign reset_ctrl     = reset;
    assign mode_in        = mode_t'(mode);
    assign unused_read_hi = ^read_data[31:24];

    neopixel_frame_timer #(
        .C_RATE (C_RATE)
    ) u_frame_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .trigger (trigger)
    );

    // Colour for a written pixel in the write-only modes.
    function automatic logic [31:0] pattern(input mode_t m, input logic [31:0] a);
        if (m == MODE_CHASE && a != chase_pos) begin
            return 32'h0;
        end
        return {8'h00, base_colour};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_INCREMENT;
            write_readf   <= 1'b0;
            address       <= '0;
            write_data    <= '0;
            base_colour   <= '0;
            chase_pos     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            missed_frames <= '0;
        end else begin
            frame_done <= 1'b0;

            // Any trigger outside IDLE belongs to a frame still in progress.
            if (trigger && state != ST_IDLE && missed_frames != 8'hFF) begin
                missed_frames <= missed_frames + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (trigger && mode_in != MODE_HOLD) begin
                        mode_q  <= mode_in;
                        address <= '0;
                        busy    <= 1'b1;
                        if (mode_in == MODE_FADE) begin
                            state       <= ST_READ;
                            write_readf <= 1'b0;
                        end else begin
                            state       <= ST_WRITE;
                            write_readf <= 1'b1;
                            write_data  <= pattern(mode_in, 32'h0);
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    state       <= ST_WRITE;
                    write_readf <= 1'b1;
                    write_data  <= {8'h00, fade_colour(read_data[COLOR_W-1:0])};
                end
                ST_WRITE: begin
                    if (address == LAST_PIXEL) begin
                        state       <= ST_DONE;
                        write_readf <= 1'b0;
                        frame_done  <= 1'b1;
                        address     <= '0;
                        base_colour <= base_colour + C_STEP;
                        chase_pos   <= (chase_pos == LAST_PIXEL) ? 32'h0 : chase_pos + 32'd1;
                    end else if (mode_q == MODE_FADE) begin
                        state       <= ST_READ;
                        write_readf <= 1'b0;
                        address     <= address + 32'd1;
                    end else begin
                        address    <= address + 32'd1;
                        write_data <= pattern(mode_q, address + 32'd1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    write_readf <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_pattern_gen.sv
// Scoreboard bench: directed frames on a 4-pixel generator plus a short-period overrun instance.
module tb_neopixel_pattern_gen;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        clock_ctrl, reset_ctrl, write_readf, busy, frame_done;
    logic [31:0] address, write_data;
    logic [31:0] read_data = 32'h0080FF02;
    logic [7:0]  missed_frames;

    logic        reset_f = 1'b1;
    logic        enable_f = 1'b0;
    logic [1:0]  mode_f = 2'd2;
    logic        clock_ctrl_f, reset_ctrl_f, write_readf_f, busy_f, frame_done_f;
    logic [31:0] address_f, write_data_f;
    logic [7:0]  missed_frames_f;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    int   first_wr_cyc = 0;
    int   wr_seen = 0;
    int   done_seen = 0;
    int   frames_f = 0;
    bit   busy_prev = 1'b0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    neopixel_pattern_gen #(.C_RATE(64), .C_PIXELS(4), .C_STEP(24'h040201)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .clock_ctrl(clock_ctrl), .reset_ctrl(reset_ctrl), .write_readf(write_readf),
        .address(address), .write_data(write_data), .read_data(read_data),
        .busy(busy), .frame_done(frame_done), .missed_frames(missed_frames)
    );

    neopixel_pattern_gen #(.C_RATE(8), .C_PIXELS(4), .C_STEP(24'h040201)) dut_fast (
        .clock(clock), .reset(reset_f), .enable(enable_f), .mode(mode_f),
        .clock_ctrl(clock_ctrl_f), .reset_ctrl(reset_ctrl_f), .write_readf(write_readf_f),
        .address(address_f), .write_data(write_data_f), .read_data(read_data),
        .busy(busy_f), .frame_done(frame_done_f), .missed_frames(missed_frames_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.addr = 32'h0; e.data = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout with %0d expected events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(posedge clock) cyc++;

    // Monitor: every strobe / frame_done pops the next expected event.
    always @(negedge clock) begin
        exp_t e;
        if (busy && !busy_prev) start_cyc = cyc;
        busy_prev = busy;
        if (write_readf) begin
            wr_seen++;
            if (address == 32'h0) first_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", address, write_data);
            end else begin
                e = exp_q.pop_front();
                chk("write_is_not_done", 32'(e.is_done), 32'h0);
                chk("write_addr", address, e.addr);
                chk("write_data", write_data, e.data);
            end
        end
        if (frame_done) begin
            done_seen++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_frame_done: got pulse, required none");
            end else begin
                e = exp_q.pop_front();
                chk("frame_done_expected", 32'(e.is_done), 32'h1);
            end
        end
    end

    // Overrun instance: one dropped trigger per frame, saturating at 255.
    always @(negedge clock) begin
        if (write_readf_f) chk("fast_fade_data", write_data_f, 32'h00407F01);
        if (frame_done_f) begin
            frames_f++;
            chk("missed_frames", 32'(missed_frames_f), (frames_f > 255) ? 32'd255 : 32'(frames_f));
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] base;
        int n;
        int wr0, dn0;

        // Reset state
        do_reset();
        chk("reset_write_readf", 32'(write_readf), 32'h0);
        chk("reset_address", address, 32'h0);
        chk("reset_write_data", write_data, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        chk("reset_missed", 32'(missed_frames), 32'h0);
        chk("clock_fwd", 32'(clock_ctrl), 32'(clock));
        chk("reset_fwd", 32'(reset_ctrl), 32'(reset));

        // INCREMENT: frame 1 all zero, frame 2 all 0x040201
        mode = 2'd0;
        for (int a = 0; a < 4; a++) push_wr(32'(a), 32'h0);
        push_done();
        for (int a = 0; a < 4; a++) push_wr(32'(a), 32'h00040201);
        push_done();
        enable = 1'b1;
        wait_drain(300, "increment_frames");
        chk("increment_busy_after", 32'(busy), 32'h0);
        chk("increment_missed", 32'(missed_frames), 32'h0);

        // CHASE: 5 frames, lit pixel walks and wraps
        do_reset();
        mode = 2'd1;
        base = 24'h0;
        for (int f = 0; f < 5; f++) begin
            for (int a = 0; a < 4; a++) push_wr(32'(a), (a == f % 4) ? {8'h0, base} : 32'h0);
            push_done();
            base = base + 24'h040201;
        end
        enable = 1'b1;
        wait_drain(5 * 64 + 60, "chase_frames");

        // FADE: read 0x80FF02, write 0x407F01, 3 cycles/pixel
        do_reset();
        mode = 2'd2;
        for (int a = 0; a < 4; a++) push_wr(32'(a), 32'h00407F01);
        push_done();
        enable = 1'b1;
        wait_drain(120, "fade_frame");
        enable = 1'b0;
        chk("fade_first_write_latency", 32'(first_wr_cyc - start_cyc), 32'd2);
        chk("fade_done_latency", 32'(done_cyc - start_cyc), 32'd12);

        // Mode switch and enable drop mid-frame: frame still completes
        do_reset();
        mode = 2'd0;
        for (int a = 0; a < 4; a++) push_wr(32'(a), 32'h0);
        push_done();
        enable = 1'b1;
        n = 0;
        while (!(write_readf && address == 32'd2) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("reach_addr2", 32'(write_readf && address == 32'd2), 32'h1);
        mode   = 2'd3;
        enable = 1'b0;
        wait_drain(20, "midframe_complete");
        repeat (100) @(negedge clock);
        chk("midframe_idle_busy", 32'(busy), 32'h0);

        // Reset in the middle of a frame
        mode   = 2'd0;
        enable = 1'b1;
        push_wr(32'd0, 32'h00040201);
        push_wr(32'd1, 32'h00040201);
        n = 0;
        while (!(write_readf && address == 32'd1) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("reach_addr1", 32'(write_readf && address == 32'd1), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_write_readf", 32'(write_readf), 32'h0);
        chk("midreset_address", address, 32'h0);
        chk("midreset_busy", 32'(busy), 32'h0);
        chk("midreset_write_data", write_data, 32'h0);
        reset  = 1'b0;
        enable = 1'b0;
        chk("midreset_queue_empty", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // HOLD: no bus activity over 3 trigger periods
        do_reset();
        mode = 2'd3;
        wr0 = wr_seen;
        dn0 = done_seen;
        enable = 1'b1;
        repeat (3 * 64 + 10) @(negedge clock);
        enable = 1'b0;
        chk("hold_no_writes", 32'(wr_seen - wr0), 32'h0);
        chk("hold_no_done", 32'(done_seen - dn0), 32'h0);
        chk("hold_busy", 32'(busy), 32'h0);

        // Overrun: short period, mode 2, run past saturation
        @(negedge clock);
        reset_f = 1'b1;
        repeat (2) @(negedge clock);
        reset_f  = 1'b0;
        chk("fast_reset_missed", 32'(missed_frames_f), 32'h0);
        enable_f = 1'b1;
        n = 0;
        while (frames_f < 262 && n < 262 * 16 + 100) begin
            @(negedge clock);
            n++;
        end
        chk("fast_frames_reached", 32'(frames_f >= 262), 32'h1);
        chk("fast_missed_saturated", 32'(missed_frames_f), 32'd255);
        enable_f = 1'b0;

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/neopixel_pattern_gen.md
NEOPIXEL_PATTERN_GEN -- requirements
Module: neopixel_pattern_gen

Interface
REQ-001 SHALL have parameter C_RATE, default 125000000, clocks between frame triggers (>= 4*C_PIXELS+2).
REQ-002 SHALL have parameter C_PIXELS, default 12, number of pixels addressed per frame (2..256).
REQ-003 SHALL have parameter C_STEP, default 24'h040201, added to the base colour after each frame.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run frame timer when high.
REQ-007 SHALL have port mode  input  2  0=INCREMENT, 1=CHASE, 2=FADE, 3=HOLD.
REQ-008 SHALL have port clock_ctrl  output  1  clock forwarded to the control interface.
REQ-009 SHALL have port reset_ctrl  output  1  reset forwarded to the control interface.
REQ-010 SHALL have port write_readf  output  1  1=write strobe, one cycle per pixel write.
REQ-011 SHALL have port address  output  32  pixel index, 0..C_PIXELS-1.
REQ-012 SHALL have port write_data  output  32  pixel colour, bits 31:24 always 0.
REQ-013 SHALL have port read_data  input  32  pixel colour, valid one cycle after address is presented with write_readf=0.
REQ-014 SHALL have port busy  output  1  high from frame start through DONE.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when a frame completes.
REQ-016 SHALL have port missed_frames  output  8  saturating count of triggers dropped while busy.

Function
REQ-017 SHALL count clocks 1..C_RATE while enable=1, raising a one-cycle trigger when the count reaches C_RATE, then reloading to 1; enable=0 SHALL clear the counter.
REQ-018 SHALL use FSM states IDLE, READ, READ_WAIT, WRITE, DONE.
REQ-019 SHALL, on a trigger in IDLE with mode!=3, latch mode, set address=0, assert busy, and enter WRITE (modes 0/1) or READ (mode 2).
REQ-020 SHALL, on a trigger in IDLE with mode=3, stay in IDLE with no bus activity.
REQ-021 SHALL, in modes 0/1, issue C_PIXELS consecutive write strobes, address incrementing by 1 per cycle.
REQ-022 SHALL, in mode 0, drive write_data = base colour for every pixel.
REQ-023 SHALL, in mode 1, drive write_data = base colour when address==chase_pos, else 0.
REQ-024 SHALL, in mode 2, per pixel: READ (present address, write_readf=0), READ_WAIT (capture read_data), WRITE (each of bytes 23:16, 15:8, 7:0 shifted right 1) -- 3 cycles per pixel.
REQ-025 SHALL, after the write to address C_PIXELS-1, enter DONE for one cycle: pulse frame_done, add C_STEP to base colour modulo 2^24, advance chase_pos with wrap C_PIXELS-1 -> 0, then return to IDLE with busy=0 and address=0.
REQ-026 SHALL ignore mode changes and enable deassertion mid-frame; the latched frame completes.
REQ-027 SHALL, on a trigger while busy, drop it and increment missed_frames, saturating at 255.
REQ-028 SHALL hold write_readf low in every state except WRITE.

Reset
REQ-029 SHALL, on reset, force IDLE, timer=0, write_readf=0, address=0, write_data=0, base colour=0, chase_pos=0, busy=0, frame_done=0, missed_frames=0, effective next cycle including mid-frame.
REQ-030 SHALL drive clock_ctrl=clock and reset_ctrl=reset combinationally.

Structure
REQ-031 SHALL take mode encodings, FSM state encodings and the colour width (24) from a shared package neopixel_pkg.
REQ-032 SHALL implement the frame timer as sub-module neopixel_frame_timer (enable in, trigger out, C_RATE parameter).

Verification
REQ-033 SHALL cover C_RATE=64, C_PIXELS=4, mode 0, enable at t0: first strobes at addr 0..3 with data 0, frame_done; second frame writes 0x040201 to all 4 pixels.
REQ-034 SHALL cover mode 1 across 5 frames: lit pixel at addresses 0,1,2,3,0 with data 0, 0x040201, 0x080402, 0x0C0603, 0x100804.
REQ-035 SHALL cover mode 2 with read_data model returning 0x80FF02: each pixel written 0x407F01, 3 cycles per pixel, frame_done at cycle 12 after start.
REQ-036 SHALL cover C_RATE=8, C_PIXELS=4, mode 2 (frame exceeds period): missed_frames increments per dropped trigger and saturates at 255.
REQ-037 SHALL cover mode switched 0->3 and enable dropped at address 2: frame completes through address 3; reset at address 1: next cycle write_readf=0, address=0, busy=0.
REQ-038 SHALL cover mode 3: no write strobes and no frame_done over 3 trigger periods.
